// File: rtl/bus_wait_ctrl.sv
// bus_wait_ctrl: registers the mapped address, classifies each bus cycle as
// FAST / SLOW / IO and stretches it with wait states. IO cycles run a
// req/ack handshake backed by a timeout that forces completion with 8'hFF.
module bus_wait_ctrl #(
    parameter logic [19:0] IO_BASE    = 20'h0D000,
    parameter logic [19:0] IO_MASK    = 20'hFF000,
    parameter logic [19:0] SLOW_BASE  = 20'h20000,
    parameter logic [19:0] SLOW_MASK  = 20'hE0000,
    parameter int          WAIT_SLOW  = 2,
    parameter int          IO_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] address_next,
    input  logic        map_next,
    input  logic        we_next,
    input  logic [7:0]  data_o,
    input  logic        ext_hold,
    input  logic [7:0]  mem_rdata,
    input  logic        io_ack,
    input  logic [7:0]  io_rdata,
    input  logic        timeout_clr,
    output logic        ready,
    output logic [19:0] bus_addr,
    output logic        bus_map,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    output logic        io_req,
    output logic [1:0]  cycle_class,
    output logic [7:0]  core_data_i,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        ST_FAST      = 2'd0,
        ST_SLOW_WAIT = 2'd1,
        ST_IO_WAIT   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam logic [1:0] CLS_FAST = 2'd0;
    localparam logic [1:0] CLS_SLOW = 2'd1;
    localparam logic [1:0] CLS_IO   = 2'd2;

    // Counters only ever count up to parameter-1, so clog2 of the parameter
    // is enough; the guard keeps the width legal for parameter values of 0/1.
    localparam int SCW = (WAIT_SLOW  > 1) ? $clog2(WAIT_SLOW)  : 1;
    localparam int TCW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [SCW-1:0] SLOW_INIT = SCW'((WAIT_SLOW > 0) ? (WAIT_SLOW - 1) : 0);
    localparam logic [TCW-1:0] TMR_LAST  = TCW'((IO_TIMEOUT > 0) ? (IO_TIMEOUT - 1) : 0);

    state_t         r_state;
    logic [SCW-1:0] r_slow_cnt;
    logic [TCW-1:0] r_tmr;
    logic [19:0]    r_addr;
    logic           r_map;
    logic           r_we;
    logic [1:0]     r_cls;
    logic [7:0]     r_io_data;
    logic           r_tflag;

    state_t         w_state_nxt;
    logic [SCW-1:0] w_slow_cnt_nxt;
    logic [TCW-1:0] w_tmr_nxt;
    logic           w_io_hit;
    logic           w_slow_hit;
    logic [1:0]     w_launch_cls;
    logic           w_ready;
    logic           w_io_done;
    logic           w_io_timeout;

    // Region decode of the incoming address; IO has priority over SLOW, and a
    // zero wait count demotes the slow region to a plain fast cycle.
    always_comb begin
        w_io_hit     = ((address_next & IO_MASK) == IO_BASE);
        w_slow_hit   = ((address_next & SLOW_MASK) == SLOW_BASE) && (WAIT_SLOW > 0);
        w_launch_cls = CLS_FAST;
        if (w_io_hit)
            w_launch_cls = CLS_IO;
        else if (w_slow_hit)
            w_launch_cls = CLS_SLOW;
    end

    // A cycle completes from FAST or DONE unless the external stall holds it.
    always_comb begin
        w_ready = ((r_state == ST_FAST) || (r_state == ST_DONE)) && !ext_hold;
    end

    // Next-state logic: launches, slow-wait countdown, IO ack / timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_slow_cnt_nxt = r_slow_cnt;
        w_tmr_nxt      = r_tmr;
        w_io_done      = 1'b0;
        w_io_timeout   = 1'b0;
        case (r_state)
            ST_FAST, ST_DONE: begin
                if (w_ready) begin
                    case (w_launch_cls)
                        CLS_SLOW: begin
                            w_state_nxt    = ST_SLOW_WAIT;
                            w_slow_cnt_nxt = SLOW_INIT;
                        end
                        CLS_IO: begin
                            w_state_nxt = ST_IO_WAIT;
                            w_tmr_nxt   = '0;
                        end
                        default: w_state_nxt = ST_FAST;
                    endcase
                end
            end
            ST_SLOW_WAIT: begin
                if (r_slow_cnt == '0)
                    w_state_nxt = ST_DONE;
                else
                    w_slow_cnt_nxt = r_slow_cnt - SCW'(1);
            end
            ST_IO_WAIT: begin
                // An ack on the last timer cycle still counts as a real reply.
                if (io_ack) begin
                    w_state_nxt = ST_DONE;
                    w_io_done   = 1'b1;
                end else if (r_tmr == TMR_LAST) begin
                    w_state_nxt  = ST_DONE;
                    w_io_timeout = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + TCW'(1);
                end
            end
            default: w_state_nxt = ST_FAST;
        endcase
    end

    // State and wait/timeout counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FAST;
            r_slow_cnt <= '0;
            r_tmr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_slow_cnt <= w_slow_cnt_nxt;
            r_tmr      <= w_tmr_nxt;
        end
    end

    // Capture the launched cycle; held stable until the next launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_map  <= 1'b0;
            r_we   <= 1'b0;
            r_cls  <= CLS_FAST;
        end else if (w_ready) begin
            r_addr <= address_next;
            r_map  <= map_next;
            r_we   <= we_next;
            r_cls  <= w_launch_cls;
        end
    end

    // IO data latch: slave data on ack (also for writes), 8'hFF on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_io_data <= 8'hFF;
        else if (w_io_done)
            r_io_data <= io_rdata;
        else if (w_io_timeout)
            r_io_data <= 8'hFF;
    end

    // Sticky timeout flag; a new timeout wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tflag <= 1'b0;
        else if (w_io_timeout)
            r_tflag <= 1'b1;
        else if (timeout_clr)
            r_tflag <= 1'b0;
    end

    assign ready        = w_ready;
    assign bus_addr     = r_addr;
    assign bus_map      = r_map;
    assign bus_we       = r_we;
    assign bus_wdata    = data_o;
    assign io_req       = (r_state == ST_IO_WAIT);
    assign cycle_class  = r_cls;
    assign core_data_i  = (r_cls == CLS_IO) ? r_io_data : mem_rdata;
    assign timeout_flag = r_tflag;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Bench for bus_wait_ctrl: a transaction-level model (elapsed cycles since
// launch vs. wait budget) checked every cycle, plus directed literal checks.
module tb_bus_wait_ctrl;

    localparam int WAIT_SLOW  = 2;
    localparam int IO_TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic [19:0] address_next;
    logic        map_next;
    logic        we_next;
    logic [7:0]  data_o;
    logic        ext_hold;
    logic [7:0]  mem_rdata;
    logic        io_ack;
    logic [7:0]  io_rdata;
    logic        timeout_clr;
    logic        ready;
    logic [19:0] bus_addr;
    logic        bus_map;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic        io_req;
    logic [1:0]  cycle_class;
    logic [7:0]  core_data_i;
    logic        timeout_flag;

    bus_wait_ctrl #(
        .IO_BASE(20'h0D000), .IO_MASK(20'hFF000),
        .SLOW_BASE(20'h20000), .SLOW_MASK(20'hE0000),
        .WAIT_SLOW(WAIT_SLOW), .IO_TIMEOUT(IO_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .address_next(address_next), .map_next(map_next),
        .we_next(we_next), .data_o(data_o), .ext_hold(ext_hold), .mem_rdata(mem_rdata),
        .io_ack(io_ack), .io_rdata(io_rdata), .timeout_clr(timeout_clr),
        .ready(ready), .bus_addr(bus_addr), .bus_map(bus_map), .bus_we(bus_we),
        .bus_wdata(bus_wdata), .io_req(io_req), .cycle_class(cycle_class),
        .core_data_i(core_data_i), .timeout_flag(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A cycle is "done" once its wait budget is spent: SLOW after WAIT_SLOW
    // clocks, IO on ack or after IO_TIMEOUT clocks. FAST is done at launch.
    logic [19:0] m_addr;
    logic        m_map, m_we;
    int          m_cls;
    int          m_elapsed;
    bit          m_done;
    logic [7:0]  m_data;
    bit          m_tflag;
    bit          m_set;

    function automatic int classify(input logic [19:0] a);
        if ((a & 20'hFF000) == 20'h0D000) return 2;
        if (WAIT_SLOW > 0 && (a & 20'hE0000) == 20'h20000) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_addr = '0; m_map = 0; m_we = 0; m_cls = 0; m_elapsed = 0;
            m_done = 1; m_data = 8'hFF; m_tflag = 0;
        end else begin
            m_set = 0;
            if (m_done) begin
                if (!ext_hold) begin
                    m_addr = address_next; m_map = map_next; m_we = we_next;
                    m_cls = classify(address_next);
                    m_elapsed = 0;
                    m_done = (m_cls == 0);
                end
            end else begin
                m_elapsed++;
                if (m_cls == 1) begin
                    if (m_elapsed >= WAIT_SLOW) m_done = 1;
                end else if (io_ack) begin
                    m_data = io_rdata; m_done = 1;
                end else if (m_elapsed >= IO_TIMEOUT) begin
                    m_data = 8'hFF; m_done = 1; m_set = 1;
                end
            end
            if (m_set) m_tflag = 1;
            else if (timeout_clr) m_tflag = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready",        32'(ready),        32'(m_done && !ext_hold));
            chk("io_req",       32'(io_req),       32'(!m_done && m_cls == 2));
            chk("bus_addr",     32'(bus_addr),     32'(m_addr));
            chk("bus_map",      32'(bus_map),      32'(m_map));
            chk("bus_we",       32'(bus_we),       32'(m_we));
            chk("cycle_class",  32'(cycle_class),  32'(m_cls));
            chk("core_data_i",  32'(core_data_i),  32'((m_cls == 2) ? m_data : mem_rdata));
            chk("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
            chk("bus_wdata",    32'(bus_wdata),    32'(data_o));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch an IO cycle and count io_req cycles; ack on the ack_at-th one (0 = never).
    task automatic io_txn(input logic [19:0] addr, input int ack_at, input logic [7:0] rd,
                          output int n);
        address_next = addr;
        tick();
        address_next = 20'h00400;
        n = 0;
        while (io_req === 1'b1 && n < 300) begin
            n++;
            if (n == ack_at) begin
                io_ack = 1'b1;
                io_rdata = rd;
            end
            tick();
            io_ack = 1'b0;
        end
    endtask

    int n_req;
    int ack_pct;

    initial begin
        reset = 1'b1; address_next = 20'h00100; map_next = 0; we_next = 0; data_o = 8'h00;
        ext_hold = 0; mem_rdata = 8'h11; io_ack = 0; io_rdata = 8'h00; timeout_clr = 0;
        cmp_en = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_addr",  32'(bus_addr), 32'd0);
        chk("rst_ioreq", 32'(io_req), 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // fast cycles, one cycle of latency
        address_next = 20'h00200; tick();
        chk("t1_addr", 32'(bus_addr), 32'h00200);
        chk("t1_cls",  32'(cycle_class), 32'd0);
        chk("t1_rdy",  32'(ready), 32'd1);
        address_next = 20'h00201; tick();
        chk("t1_addr2", 32'(bus_addr), 32'h00201);

        // slow cycle: two wait states
        address_next = 20'h21000; mem_rdata = 8'h3C; tick();
        address_next = 20'h00300;
        chk("t2_rdy0", 32'(ready), 32'd0);
        chk("t2_addr", 32'(bus_addr), 32'h21000);
        chk("t2_cls",  32'(cycle_class), 32'd1);
        chk("t2_data", 32'(core_data_i), 32'h3C);
        tick();
        chk("t2_rdy1", 32'(ready), 32'd0);
        tick();
        chk("t2_rdy2", 32'(ready), 32'd1);
        chk("t2_addr2", 32'(bus_addr), 32'h21000);
        tick();

        // IO read acked on the third wait cycle
        io_txn(20'h0D020, 3, 8'h5A, n_req);
        chk("t3_len",  32'(n_req), 32'd3);
        chk("t3_rdy",  32'(ready), 32'd1);
        chk("t3_data", 32'(core_data_i), 32'h5A);
        chk("t3_tfl",  32'(timeout_flag), 32'd0);

        // IO timeout
        io_txn(20'h0D030, 0, 8'h00, n_req);
        chk("t4_len",  32'(n_req), 32'd64);
        chk("t4_data", 32'(core_data_i), 32'hFF);
        chk("t4_tfl",  32'(timeout_flag), 32'd1);
        timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
        chk("t4_clr", 32'(timeout_flag), 32'd0);

        // ack on the timeout cycle wins
        io_txn(20'h0D040, 64, 8'hA7, n_req);
        chk("t5_len",  32'(n_req), 32'd64);
        chk("t5_data", 32'(core_data_i), 32'hA7);
        chk("t5_tfl",  32'(timeout_flag), 32'd0);
        ext_hold = 1'b1; address_next = 20'h00500;
        repeat (3) begin
            tick();
            chk("t5_hold_rdy",  32'(ready), 32'd0);
            chk("t5_hold_addr", 32'(bus_addr), 32'h0D040);
        end
        ext_hold = 1'b0; #1;
        chk("t5_rel_rdy", 32'(ready), 32'd1);
        tick();
        chk("t5_rel_addr", 32'(bus_addr), 32'h00500);

        // timeout set beats a clear held through the whole cycle
        timeout_clr = 1'b1;
        io_txn(20'h0D050, 0, 8'h00, n_req);
        chk("t5b_tfl", 32'(timeout_flag), 32'd1);
        tick(); timeout_clr = 1'b0;
        chk("t5b_clr", 32'(timeout_flag), 32'd0);

        // async reset in the middle of an IO wait
        address_next = 20'h0D060; tick();
        address_next = 20'h00600; tick(); tick();
        chk("t6_req_pre", 32'(io_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_req",  32'(io_req), 32'd0);
        chk("t6_rdy",  32'(ready), 32'd1);
        chk("t6_addr", 32'(bus_addr), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        address_next = 20'h21234; tick();
        chk("t6_cls", 32'(cycle_class), 32'd1);
        chk("t6_rdy0", 32'(ready), 32'd0);
        address_next = 20'h00700;
        repeat (3) tick();

        // randomized traffic
        ack_pct = 20;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_pct = 0;
                    1: ack_pct = 5;
                    default: ack_pct = 40;
                endcase
            end
            case ($urandom_range(0, 2))
                0: address_next = 20'h0D000 | (20'($urandom) & 20'h00FFF);
                1: address_next = 20'h20000 | (20'($urandom) & 20'h1FFFF);
                default: address_next = 20'($urandom);
            endcase
            map_next    = 1'($urandom);
            we_next     = 1'($urandom);
            data_o      = 8'($urandom);
            mem_rdata   = 8'($urandom);
            io_rdata    = 8'($urandom);
            ext_hold    = ($urandom_range(0, 99) < 25);
            io_ack      = ($urandom_range(0, 99) < ack_pct);
            timeout_clr = ($urandom_range(0, 99) < 5);
            tick();
        end

        @(negedge clk);
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
